// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - branch condition codes, reset/exception defaults and condition evaluation
package npc_pkg;

    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_BLEZ = 3'd2;
    localparam logic [2:0] BR_BGTZ = 3'd3;
    localparam logic [2:0] BR_BLTZ = 3'd4;
    localparam logic [2:0] BR_BGEZ = 3'd5;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_JR   = 2'd1,
        SRC_J    = 2'd2,
        SRC_BR   = 2'd3
    } ctrl_src_e;

    // Codes 6 and 7 are reserved and never taken.
    function automatic logic cond_taken(input logic [2:0]  cond,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        logic signed [31:0] sa;
        sa = $signed(a);
        case (cond)
            BR_BEQ:  cond_taken = (a == b);
            BR_BNE:  cond_taken = (a != b);
            BR_BLEZ: cond_taken = (sa <= 32'sd0);
            BR_BGTZ: cond_taken = (sa >  32'sd0);
            BR_BLTZ: cond_taken = (sa <  32'sd0);
            BR_BGEZ: cond_taken = (sa >= 32'sd0);
            default: cond_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/npc_target_calc.sv
// rtl/npc_target_calc.sv - branch condition, jr/j/branch target select and link value (PC_SEQ_DELAY_SLOT_EN selects link offset)
module npc_target_calc
    import npc_pkg::*;
#(
    parameter int IMM_W = 16,
    parameter int IDX_W = 26
) (
    input  logic             br_en,
    input  logic [2:0]       br_cond,
    input  logic [31:0]      cmp_a,
    input  logic [31:0]      cmp_b,
    input  logic [31:0]      br_pc,
    input  logic [IMM_W-1:0] imm,
    input  logic             j_en,
    input  logic [IDX_W-1:0] idx,
    input  logic             jr_en,
    input  logic [31:0]      jr_target,
    output logic             ctrl_valid,
    output logic [31:0]      ctrl_target,
    output logic [31:0]      link_pc
);

    // Low bits of the jump target come from the index; the rest from br_pc+4.
    localparam logic [31:0] JMP_LO_MASK = 32'((64'd1 << (IDX_W + 2)) - 64'd1);

    logic [31:0] w_seq;
    logic [31:0] w_br_off;
    logic [31:0] w_br_target;
    logic [31:0] w_jmp_target;
    logic        w_taken;
    ctrl_src_e   w_src;

    assign w_seq        = br_pc + 32'd4;
    assign w_br_off     = 32'($signed(imm)) << 2;
    assign w_br_target  = w_seq + w_br_off;
    assign w_jmp_target = (w_seq & ~JMP_LO_MASK) | (32'(idx) << 2);
    assign w_taken      = cond_taken(br_cond, cmp_a, cmp_b);

    always_comb begin
        w_src = SRC_NONE;
        if (jr_en) begin
            w_src = SRC_JR;
        end else if (j_en) begin
            w_src = SRC_J;
        end else if (br_en && w_taken) begin
            w_src = SRC_BR;
        end
    end

    always_comb begin
        ctrl_target = w_br_target;
        case (w_src)
            SRC_JR:  ctrl_target = jr_target;
            SRC_J:   ctrl_target = w_jmp_target;
            default: ctrl_target = w_br_target;
        endcase
    end

    assign ctrl_valid = (w_src != SRC_NONE);

`ifdef PC_SEQ_DELAY_SLOT_EN
    assign link_pc = br_pc + 32'd8;
`else
    assign link_pc = w_seq;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - architectural PC, fetch handshake and held redirects (optional PC_SEQ_DELAY_SLOT_EN)
module pc_sequencer
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF,
    parameter int          IMM_W    = 16,
    parameter int          IDX_W    = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    output logic             fetch_valid,
    input  logic             fetch_ready,
    input  logic             br_en,
    input  logic [2:0]       br_cond,
    input  logic [31:0]      cmp_a,
    input  logic [31:0]      cmp_b,
    input  logic [31:0]      br_pc,
    input  logic [IMM_W-1:0] imm,
    input  logic             j_en,
    input  logic [IDX_W-1:0] idx,
    input  logic             jr_en,
    input  logic [31:0]      jr_target,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [31:0]      epc,
    output logic [31:0]      pc,
    output logic [31:0]      pc4,
    output logic [31:0]      link_pc,
    output logic             redirect,
    output logic             pc_misaligned
);

    logic [31:0] r_pc;
    logic        r_fetch_valid;
    logic        r_redirect;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_pc4;
    logic        w_redirect_nxt;
    logic        w_advance;
    logic        w_ctrl_valid;
    logic [31:0] w_ctrl_target;

`ifdef PC_SEQ_DELAY_SLOT_EN
    logic        r_ds_valid;
    logic        r_ds_armed;
    logic [31:0] r_ds_target;
    logic        w_ds_valid_nxt;
    logic        w_ds_armed_nxt;
    logic [31:0] w_ds_target_nxt;
`else
    logic        r_pend_valid;
    logic [31:0] r_pend_target;
    logic        w_pend_valid_nxt;
    logic [31:0] w_pend_target_nxt;
`endif

    npc_target_calc #(
        .IMM_W (IMM_W),
        .IDX_W (IDX_W)
    ) u_calc (
        .br_en       (br_en),
        .br_cond     (br_cond),
        .cmp_a       (cmp_a),
        .cmp_b       (cmp_b),
        .br_pc       (br_pc),
        .imm         (imm),
        .j_en        (j_en),
        .idx         (idx),
        .jr_en       (jr_en),
        .jr_target   (jr_target),
        .ctrl_valid  (w_ctrl_valid),
        .ctrl_target (w_ctrl_target),
        .link_pc     (link_pc)
    );

    assign w_advance = r_fetch_valid & fetch_ready & ~stall;
    assign w_pc4     = r_pc + 32'd4;

`ifdef PC_SEQ_DELAY_SLOT_EN
    // ds_armed means the delay-slot fetch has been accepted; the next advance jumps.
    always_comb begin
        w_pc_nxt        = r_pc;
        w_redirect_nxt  = 1'b0;
        w_ds_valid_nxt  = r_ds_valid;
        w_ds_armed_nxt  = r_ds_armed;
        w_ds_target_nxt = r_ds_target;
        if (exc_req || eret_req) begin
            w_pc_nxt       = exc_req ? EXC_VEC : epc;
            w_redirect_nxt = 1'b1;
            w_ds_valid_nxt = 1'b0;
            w_ds_armed_nxt = 1'b0;
        end else if (w_ctrl_valid) begin
            w_ds_valid_nxt  = 1'b1;
            w_ds_target_nxt = w_ctrl_target;
            w_ds_armed_nxt  = w_advance;
            if (w_advance) begin
                w_pc_nxt = w_pc4;
            end
        end else if (w_advance) begin
            if (r_ds_valid && r_ds_armed) begin
                w_pc_nxt       = r_ds_target;
                w_redirect_nxt = 1'b1;
                w_ds_valid_nxt = 1'b0;
                w_ds_armed_nxt = 1'b0;
            end else begin
                w_pc_nxt = w_pc4;
                if (r_ds_valid) begin
                    w_ds_armed_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ds_valid  <= 1'b0;
            r_ds_armed  <= 1'b0;
            r_ds_target <= '0;
        end else begin
            r_ds_valid  <= w_ds_valid_nxt;
            r_ds_armed  <= w_ds_armed_nxt;
            r_ds_target <= w_ds_target_nxt;
        end
    end
`else
    // A fresh redirect always replaces whatever is pending.
    always_comb begin
        w_pc_nxt          = r_pc;
        w_redirect_nxt    = 1'b0;
        w_pend_valid_nxt  = r_pend_valid;
        w_pend_target_nxt = r_pend_target;
        if (exc_req || eret_req) begin
            w_pc_nxt         = exc_req ? EXC_VEC : epc;
            w_redirect_nxt   = 1'b1;
            w_pend_valid_nxt = 1'b0;
        end else if (w_ctrl_valid) begin
            if (w_advance) begin
                w_pc_nxt         = w_ctrl_target;
                w_redirect_nxt   = 1'b1;
                w_pend_valid_nxt = 1'b0;
            end else begin
                w_pend_valid_nxt  = 1'b1;
                w_pend_target_nxt = w_ctrl_target;
            end
        end else if (w_advance) begin
            if (r_pend_valid) begin
                w_pc_nxt         = r_pend_target;
                w_redirect_nxt   = 1'b1;
                w_pend_valid_nxt = 1'b0;
            end else begin
                w_pc_nxt = w_pc4;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else begin
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend_target <= w_pend_target_nxt;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_fetch_valid <= 1'b0;
            r_redirect    <= 1'b0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_fetch_valid <= 1'b1;
            r_redirect    <= w_redirect_nxt;
        end
    end

    assign pc            = r_pc;
    assign pc4           = w_pc4;
    assign fetch_valid   = r_fetch_valid;
    assign redirect      = r_redirect;
    assign pc_misaligned = |r_pc[1:0];

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized reference-model bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        br_en;
    logic [2:0]  br_cond;
    logic [31:0] cmp_a;
    logic [31:0] cmp_b;
    logic [31:0] br_pc;
    logic [15:0] imm;
    logic        j_en;
    logic [25:0] idx;
    logic        jr_en;
    logic [31:0] jr_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] link_pc;
    logic        redirect;
    logic        pc_misaligned;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .fetch_valid   (fetch_valid),
        .fetch_ready   (fetch_ready),
        .br_en         (br_en),
        .br_cond       (br_cond),
        .cmp_a         (cmp_a),
        .cmp_b         (cmp_b),
        .br_pc         (br_pc),
        .imm           (imm),
        .j_en          (j_en),
        .idx           (idx),
        .jr_en         (jr_en),
        .jr_target     (jr_target),
        .exc_req       (exc_req),
        .eret_req      (eret_req),
        .epc           (epc),
        .pc            (pc),
        .pc4           (pc4),
        .link_pc       (link_pc),
        .redirect      (redirect),
        .pc_misaligned (pc_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic bit ref_taken(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (c)
            3'd0: return sa == sb;
            3'd1: return sa != sb;
            3'd2: return sa <= 0;
            3'd3: return sa > 0;
            3'd4: return sa < 0;
            3'd5: return sa >= 0;
            default: return 1'b0;
        endcase
    endfunction

    logic [31:0] m_pc;
    bit          m_fv;
    bit          m_rd;
    bit          m_adv;
    bit          m_hit;
    logic [31:0] m_t;
    logic [31:0] pend_q[$];
    int          ds_need;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 32'h0000_3000;
            m_fv = 0;
            m_rd = 0;
            pend_q.delete();
            ds_need = 0;
        end else begin
            m_adv = m_fv && fetch_ready && !stall;
            m_hit = 1;
            if (jr_en) m_t = jr_target;
            else if (j_en) m_t = ((br_pc + 32'd4) & 32'hF000_0000) | {idx, 2'b00};
            else if (br_en && ref_taken(br_cond, cmp_a, cmp_b))
                m_t = br_pc + 32'd4 + 32'($signed(imm)) * 32'd4;
            else m_hit = 0;
            m_rd = 0;
            if (exc_req) begin
                m_pc = 32'h0000_4180; m_rd = 1; pend_q.delete();
            end else if (eret_req) begin
                m_pc = epc; m_rd = 1; pend_q.delete();
`ifdef PC_SEQ_DELAY_SLOT_EN
            end else if (m_hit) begin
                pend_q.delete();
                pend_q.push_back(m_t);
                ds_need = m_adv ? 0 : 1;
                if (m_adv) m_pc = m_pc + 32'd4;
            end else if (m_adv) begin
                if (pend_q.size() > 0 && ds_need == 0) begin
                    m_pc = pend_q.pop_front(); m_rd = 1;
                end else begin
                    m_pc = m_pc + 32'd4;
                    ds_need = 0;
                end
            end
`else
            end else if (m_hit) begin
                pend_q.delete();
                if (m_adv) begin
                    m_pc = m_t; m_rd = 1;
                end else begin
                    pend_q.push_back(m_t);
                end
            end else if (m_adv) begin
                if (pend_q.size() > 0) begin
                    m_pc = pend_q.pop_front(); m_rd = 1;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
`endif
            m_fv = 1;
        end
    end

`ifdef PC_SEQ_DELAY_SLOT_EN
    localparam logic [31:0] LINK_OFF = 32'd8;
`else
    localparam logic [31:0] LINK_OFF = 32'd4;
`endif

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("pc", pc, m_pc);
            cmp("fetch_valid", 32'(fetch_valid), 32'(m_fv));
            cmp("redirect", 32'(redirect), 32'(m_rd));
            cmp("pc4", pc4, m_pc + 32'd4);
            cmp("link_pc", link_pc, br_pc + LINK_OFF);
            cmp("pc_misaligned", 32'(pc_misaligned), 32'((m_pc % 4) != 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        br_en = 0; j_en = 0; jr_en = 0; exc_req = 0; eret_req = 0;
    endtask

    task automatic expect_redirect(input string nm, input logic [31:0] tgt);
`ifdef PC_SEQ_DELAY_SLOT_EN
        logic [31:0] p0;
        p0 = pc;
        cyc();
        idle();
        cmp({nm, "_slot"}, pc, p0 + 32'd4);
`endif
        cyc();
        idle();
        cmp(nm, pc, tgt);
        cmp({nm, "_redirect"}, 32'(redirect), 32'd1);
    endtask

    function automatic logic [31:0] pick_val();
        if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 4)) - 32'd2;
        return $urandom;
    endfunction

    initial begin
        reset = 1; stall = 0; fetch_ready = 0; idle();
        br_cond = 0; cmp_a = 0; cmp_b = 0; br_pc = 0; imm = 0; idx = 0;
        jr_target = 0; epc = 0;
        repeat (2) cyc();
        cmp("rst_pc", pc, 32'h0000_3000);
        cmp("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        cmp("rst_redirect", 32'(redirect), 32'd0);
        chk_en = 1;
        reset = 0;
        fetch_ready = 1;
        cyc();
        cmp("first_pc", pc, 32'h0000_3000);
        cmp("first_fetch_valid", 32'(fetch_valid), 32'd1);
        cyc(); cmp("seq1", pc, 32'h0000_3004);
        cyc(); cmp("seq2", pc, 32'h0000_3008);
        cyc(); cmp("seq3", pc, 32'h0000_300C);

        br_en = 1; br_cond = 3'd0; cmp_a = 5; cmp_b = 5; br_pc = 32'h3004; imm = 16'hFFFF;
        expect_redirect("beq_taken", 32'h0000_3004);
        cyc();
        br_en = 1; br_cond = 3'd0; cmp_a = 5; cmp_b = 6; br_pc = 32'h3004; imm = 16'hFFFF;
        cyc(); idle();
        cmp("beq_not_taken", pc, 32'h0000_300C);
        cmp("beq_not_taken_rd", 32'(redirect), 32'd0);

        stall = 1; jr_en = 1; jr_target = 32'h3100;
        cyc(); idle();
        cyc();
        cmp("jr_stall_hold", pc, 32'h0000_300C);
        stall = 0;
        expect_redirect("jr_pend", 32'h0000_3100);

        stall = 1; fetch_ready = 0; jr_en = 1; jr_target = 32'h3200;
        cyc(); idle();
        exc_req = 1;
        cyc(); idle();
        cmp("exc_pc", pc, 32'h0000_4180);
        cmp("exc_redirect", 32'(redirect), 32'd1);
        stall = 0; fetch_ready = 1;
        cyc();
        cmp("exc_pend_cleared", pc, 32'h0000_4184);
        eret_req = 1; epc = 32'h3020;
        cyc(); idle();
        cmp("eret_pc", pc, 32'h0000_3020);

        j_en = 1; br_pc = 32'h3000; idx = 26'h0000C40;
        expect_redirect("jump", 32'h0000_3100);

        jr_en = 1; jr_target = 32'hFFFF_FFFC;
        expect_redirect("jr_top", 32'hFFFF_FFFC);
        cyc();
        cmp("wrap", pc, 32'h0000_0000);

        br_en = 1; br_cond = 3'd0; cmp_a = 0; cmp_b = 0; br_pc = 32'hFFFF_FFF0; imm = 16'h0010;
        expect_redirect("br_overflow", 32'h0000_0034);

        for (int i = 0; i < 3000; i++) begin
            stall       = ($urandom_range(0, 3) == 0);
            fetch_ready = ($urandom_range(0, 3) != 0);
            br_en       = ($urandom_range(0, 6) == 0);
            j_en        = ($urandom_range(0, 11) == 0);
            jr_en       = ($urandom_range(0, 11) == 0);
            exc_req     = ($urandom_range(0, 30) == 0);
            eret_req    = ($urandom_range(0, 30) == 0);
            br_cond     = 3'($urandom_range(0, 7));
            cmp_a       = pick_val();
            cmp_b       = ($urandom_range(0, 2) == 0) ? cmp_a : pick_val();
            br_pc       = $urandom;
            imm         = 16'($urandom);
            idx         = 26'($urandom);
            jr_target   = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            epc         = $urandom & 32'hFFFF_FFFC;
            cyc();
            if (i == 1500) begin
                reset = 1;
                #1;
                cmp("midrst_pc", pc, 32'h0000_3000);
                cmp("midrst_fetch_valid", 32'(fetch_valid), 32'd0);
                cmp("midrst_redirect", 32'(redirect), 32'd0);
                cyc();
                reset = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
